index_decoder_tracker: RTL

Inverse of the priority encoder path: accepts binary indices on a set port and a clear port, decodes each to one-hot, and maintains a registered WIDTH-bit vector of active entries. The vector output feeds the priority encoder's `dec_vld` input directly, so a producer can mark slots busy by index and a consumer can retire them by index. The block also tracks a population count with full/empty flags and flags protocol misuse.

---
 rtl/index_decoder_tracker.sv | 111 +++++++++++
 1 files changed

// File: rtl/index_decoder_tracker.sv
// rtl/index_decoder_tracker.sv - index-addressed busy vector with population count
//
// Purpose: decodes a set index and a clear index to one-hot each cycle and
// keeps a registered vector of active entries, an incrementally maintained
// population count, empty/full flags and a single-cycle misuse pulse.
//
// Ports:
//   clk      in   clock, all state on its rising edge
//   rst      in   synchronous active-high reset, overrides everything
//   set_vld  in   request to set entry set_idx
//   set_idx  in   [IW-1:0] entry to set
//   clr_vld  in   request to clear entry clr_idx
//   clr_idx  in   [IW-1:0] entry to clear
//   clr_all  in   synchronous flush; discards same-cycle set/clear
//   dec_vld  out  [WIDTH-1:0] registered active-entry vector
//   cnt      out  [CW-1:0] registered number of set bits in dec_vld
//   empty    out  registered cnt == 0
//   full     out  registered cnt == WIDTH
//   err      out  registered misuse pulse, one cycle per offending request cycle
module index_decoder_tracker #(
  parameter int WIDTH = 32,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_vld,
  input  logic [IW-1:0]    set_idx,
  input  logic             clr_vld,
  input  logic [IW-1:0]    clr_idx,
  input  logic             clr_all,
  output logic [WIDTH-1:0] dec_vld,
  output logic [CW-1:0]    cnt,
  output logic             empty,
  output logic             full,
  output logic             err
);

  // Widened limit so unused index codes of a non-power-of-two WIDTH compare correctly.
  localparam logic [IW:0] LIMIT = (IW + 1)'(WIDTH);

  logic [WIDTH-1:0] dec_vld_q, dec_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic             set_in, clr_in;
  logic             set_eff, clr_eff;
  logic [WIDTH-1:0] set_oh, clr_oh;
  logic             set_cur, clr_cur;
  logic             same_idx;
  logic             inc, dec;

  always_comb begin
    set_in   = ({1'b0, set_idx} < LIMIT);
    clr_in   = ({1'b0, clr_idx} < LIMIT);
    set_eff  = set_vld & set_in;
    clr_eff  = clr_vld & clr_in;
    set_oh   = set_eff ? (WIDTH'(1) << set_idx) : '0;
    clr_oh   = clr_eff ? (WIDTH'(1) << clr_idx) : '0;
    // Current state of each target bit, read through the one-hot so an
    // out-of-range index never indexes past the vector.
    set_cur  = |(dec_vld_q & set_oh);
    clr_cur  = |(dec_vld_q & clr_oh);
    same_idx = set_eff & clr_eff & (set_idx == clr_idx);

    inc = set_eff & ~set_cur;
    // A clear hidden behind a same-index set never retires the entry.
    dec = clr_eff & clr_cur & ~same_idx;

    dec_vld_d = '0;
    cnt_d     = '0;
    err_d     = 1'b0;
    if (!clr_all) begin
      // Redundant requests leave their bit as-is, so the plain update holds.
      dec_vld_d = (dec_vld_q & ~clr_oh) | set_oh;
      cnt_d     = cnt_q + CW'(inc) - CW'(dec);
      err_d     = (set_vld & ~set_in)
                | (clr_vld & ~clr_in)
                | (set_eff & set_cur & ~same_idx)
                | (clr_eff & ~clr_cur & ~same_idx);
    end
    // Flags follow the next count so they never lag cnt by a cycle.
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_vld_q <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dec_vld_q <= dec_vld_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  assign dec_vld = dec_vld_q;
  assign cnt     = cnt_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign err     = err_q;

endmodule
